// File: rtl/rtc_write_sequencer.sv
// -----------------------------------------------------------------------------
// rtc_write_sequencer
//
// Drives a multiplexed address/data RTC bus to write a short list of
// (address, data) items.
// - A request seen in IDLE latches all inputs. INIT has priority over WRITE.
// - Each item runs three address phases, three data phases and a GAP.
// - Every phase lasts T_PHASE clock cycles.
// - After the last item the machine waits in DONE until both requests are low.
//
// Optional feature (macro RTC_WR_TRANSFER_EN):
//   A WRITE sequence whose latched clk_timer is 1 appends a command item with
//   address 0xF1. That item has address phases and GAP only.
//   With the macro undefined, a WRITE list is always three items long.
//
// Ports:
//   clk              system clock, rising edge
//   reset            asynchronous, active-low reset
//   Escribe          write-sequence request (level)
//   Inicializador_MP RTC initialisation request (level), wins over Escribe
//   clk_timer        1 = clock registers, 0 = timer registers (latched)
//   segundo/minuto/hora              data bytes for the WRITE list
//   Dir_segundo/Dir_minuto/Dir_hora  register addresses for the WRITE list
//   T_Esc            1 in DONE (sequence complete)
//   busy             1 in every state except IDLE and DONE
//   CS_n, RD_n, WR_n active-low bus strobes (RD_n is always 1)
//   A_D              0 = address phase, 1 = data phase
//   bus_oe, bus_out  bus output enable and driven byte
//   state_dbg        current FSM state, for observation
//   mode_dbg         {latched INIT select, latched clk_timer}, for observation
//
// Handshake: the request inputs are levels, not pulses. A request is
// accepted only in IDLE. It is then ignored until DONE. DONE holds T_Esc
// high until both request lines are low.
// -----------------------------------------------------------------------------
module rtc_write_sequencer #(
    parameter int T_PHASE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Escribe,
    input  logic       Inicializador_MP,
    input  logic       clk_timer,
    input  logic [7:0] segundo,
    input  logic [7:0] minuto,
    input  logic [7:0] hora,
    input  logic [7:0] Dir_segundo,
    input  logic [7:0] Dir_minuto,
    input  logic [7:0] Dir_hora,
    output logic       T_Esc,
    output logic       busy,
    output logic       CS_n,
    output logic       RD_n,
    output logic       WR_n,
    output logic       A_D,
    output logic       bus_oe,
    output logic [7:0] bus_out,
    output logic [3:0] state_dbg,
    output logic [1:0] mode_dbg
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_A_SETUP  = 4'd1;
    localparam logic [3:0] S_A_STROBE = 4'd2;
    localparam logic [3:0] S_A_HOLD   = 4'd3;
    localparam logic [3:0] S_D_SETUP  = 4'd4;
    localparam logic [3:0] S_D_STROBE = 4'd5;
    localparam logic [3:0] S_D_HOLD   = 4'd6;
    localparam logic [3:0] S_GAP      = 4'd7;
    localparam logic [3:0] S_DONE     = 4'd8;

    localparam logic [7:0] PH_LOAD  = 8'(T_PHASE - 1);
    localparam logic [7:0] CMD_ADDR = 8'hF1;

    logic [3:0] state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [1:0] item, item_n;
    logic       start;

    // Sequence context captured on IDLE exit.
    logic       is_init;
    logic       ct_lat;
    logic [7:0] addr0, addr1, addr2;
    logic [7:0] data0, data1, data2;

    logic [1:0] last_item;
    logic [7:0] cur_addr;
    logic [7:0] cur_data;

    // Index of the final item in the active list.
`ifdef RTC_WR_TRANSFER_EN
    assign last_item = (!is_init && ct_lat) ? 2'd3 : 2'd2;
`else
    assign last_item = 2'd2;
`endif

    // Next-state logic. The phase counter is loaded with T_PHASE-1 on entry
    // to each timed state. The state advances when the counter reaches 0.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        item_n  = item;
        start   = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = 8'd0;
                if (Inicializador_MP || Escribe) begin
                    state_n = S_A_SETUP;
                    cnt_n   = PH_LOAD;
                    item_n  = 2'd0;
                    start   = 1'b1;
                end
            end
            S_DONE: begin
                cnt_n = 8'd0;
                if (!Escribe && !Inicializador_MP) begin
                    state_n = S_IDLE;
                end
            end
            S_A_SETUP, S_A_STROBE, S_A_HOLD,
            S_D_SETUP, S_D_STROBE, S_D_HOLD, S_GAP: begin
                if (cnt != 8'd0) begin
                    cnt_n = cnt - 8'd1;
                end else begin
                    cnt_n = PH_LOAD;
                    case (state)
                        S_A_SETUP:  state_n = S_A_STROBE;
                        S_A_STROBE: state_n = S_A_HOLD;
                        // The command item (index 3) has no data phases.
                        S_A_HOLD:   state_n = (item == 2'd3) ? S_GAP : S_D_SETUP;
                        S_D_SETUP:  state_n = S_D_STROBE;
                        S_D_STROBE: state_n = S_D_HOLD;
                        S_D_HOLD:   state_n = S_GAP;
                        S_GAP: begin
                            if (item == last_item) begin
                                state_n = S_DONE;
                                cnt_n   = 8'd0;
                            end else begin
                                state_n = S_A_SETUP;
                                item_n  = item + 2'd1;
                            end
                        end
                        default:    state_n = S_IDLE;
                    endcase
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = 8'd0;
                item_n  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
            item  <= 2'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            item  <= item_n;
        end
    end

    // Context capture. INIT loads its fixed list into the same registers.
    // The bus path therefore does not depend on the sequence type.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_init <= 1'b0;
            ct_lat  <= 1'b0;
            addr0   <= 8'h00;
            addr1   <= 8'h00;
            addr2   <= 8'h00;
            data0   <= 8'h00;
            data1   <= 8'h00;
            data2   <= 8'h00;
        end else if (start) begin
            ct_lat <= clk_timer;
            if (Inicializador_MP) begin
                is_init <= 1'b1;
                addr0   <= 8'h02;
                data0   <= 8'h10;
                addr1   <= 8'h02;
                data1   <= 8'h00;
                addr2   <= 8'h10;
                data2   <= 8'hD2;
            end else begin
                is_init <= 1'b0;
                addr0   <= Dir_segundo;
                data0   <= segundo;
                addr1   <= Dir_minuto;
                data1   <= minuto;
                addr2   <= Dir_hora;
                data2   <= hora;
            end
        end
    end

    always_comb begin
        cur_addr = 8'h00;
        cur_data = 8'h00;
        case (item)
            2'd0: begin cur_addr = addr0;    cur_data = data0; end
            2'd1: begin cur_addr = addr1;    cur_data = data1; end
            2'd2: begin cur_addr = addr2;    cur_data = data2; end
            default: begin cur_addr = CMD_ADDR; cur_data = 8'h00; end
        endcase
    end

    // Outputs decode directly from the state register.
    // An asynchronous reset therefore releases the strobes and bus_oe at once.
    always_comb begin
        CS_n    = 1'b1;
        RD_n    = 1'b1;
        WR_n    = 1'b1;
        A_D     = 1'b0;
        bus_oe  = 1'b0;
        bus_out = 8'h00;
        T_Esc   = 1'b0;
        busy    = 1'b1;
        case (state)
            S_IDLE: busy = 1'b0;
            S_DONE: begin
                busy  = 1'b0;
                T_Esc = 1'b1;
            end
            S_A_SETUP, S_A_STROBE, S_A_HOLD: begin
                CS_n    = 1'b0;
                bus_oe  = 1'b1;
                bus_out = cur_addr;
                WR_n    = (state == S_A_STROBE) ? 1'b0 : 1'b1;
            end
            S_D_SETUP, S_D_STROBE, S_D_HOLD: begin
                CS_n    = 1'b0;
                A_D     = 1'b1;
                bus_oe  = 1'b1;
                bus_out = cur_data;
                WR_n    = (state == S_D_STROBE) ? 1'b0 : 1'b1;
            end
            S_GAP: busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign state_dbg = state;
    assign mode_dbg  = {is_init, ct_lat};

endmodule

// File: doc/rtc_write_sequencer.md
RTC_WRITE_SEQUENCER -- requirements
Module: rtc_write_sequencer

Interface
REQ-001 Parameter: T_PHASE, default 4, clock cycles per bus phase; legal range 1..255.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; reset=0 forces reset state immediately.
REQ-004 Escribe  in  1  write-sequence request from the main control machine; level-sensitive.
REQ-005 Inicializador_MP  in  1  RTC initialisation request; level-sensitive.
REQ-006 clk_timer  in  1  1 = clock registers, 0 = timer registers; latched at sequence start.
REQ-007 segundo, minuto, hora  in  8 each  data bytes to write.
REQ-008 Dir_segundo, Dir_minuto, Dir_hora  in  8 each  RTC register addresses.
REQ-009 T_Esc  out  1  sequence complete; 1 = done.
REQ-010 busy  out  1  1 while a sequence is in progress (any state except IDLE and DONE).
REQ-011 CS_n, RD_n, WR_n  out  1 each  RTC bus strobes, active-low.
REQ-012 A_D  out  1  bus phase select: 0 = address, 1 = data.
REQ-013 bus_oe  out  1  data bus output enable; bus_out  out  8  driven bus byte.

Function
REQ-014 States: IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, GAP, DONE; every state except IDLE and DONE lasts exactly T_PHASE cycles.
REQ-015 IDLE: CS_n=WR_n=RD_n=1, A_D=0, bus_oe=0, bus_out=0x00, T_Esc=0.
REQ-016 IDLE exit: Inicializador_MP=1 starts the INIT list; otherwise Escribe=1 starts the WRITE list; both high -> INIT wins.
REQ-017 On IDLE exit, all data/address inputs and clk_timer are latched; later changes are ignored until the next sequence.
REQ-018 WRITE list, in order: (Dir_segundo, segundo), (Dir_minuto, minuto), (Dir_hora, hora).
REQ-019 INIT list, in order: (0x02, 0x10), (0x02, 0x00), (0x10, 0xD2).
REQ-020 A_SETUP/A_STROBE/A_HOLD: CS_n=0, A_D=0, bus_oe=1, bus_out=item address; WR_n=0 only in A_STROBE.
REQ-021 D_SETUP/D_STROBE/D_HOLD: CS_n=0, A_D=1, bus_oe=1, bus_out=item data; WR_n=0 only in D_STROBE.
REQ-022 GAP: CS_n=1, WR_n=1, bus_oe=0; then next item's A_SETUP, or DONE after the last item.
REQ-023 RD_n stays 1 in every state.
REQ-024 Latency: first CS_n=0 in the cycle after the request is sampled in IDLE; each item takes 7*T_PHASE cycles.
REQ-025 DONE: T_Esc=1, bus idle as IDLE; T_Esc stays 1 while Escribe or Inicializador_MP is 1; return to IDLE in the first cycle both are 0 (minimum one DONE cycle).
REQ-026 Request deassertion mid-sequence: ignored; sequence completes and passes through DONE.
REQ-027 Phase counter counts T_PHASE-1 down to 0; state advances when the count is 0; item index 0..3 with no wrap past the list end.

Reset
REQ-028 reset=0: state=IDLE, counter=0, item index=0, latched registers=0x00, outputs as REQ-015; busy=0.
REQ-029 reset asserted mid-transaction: strobes released and bus_oe=0 asynchronously, no partial-write completion after release; the first request after release restarts its list from item 0.

Configuration
REQ-030 Macro RTC_WR_TRANSFER_EN defined: a WRITE sequence with latched clk_timer=1 appends a 4th command item, address 0xF1, consisting of the address phases plus GAP only, with D_* states skipped (4*T_PHASE cycles); this item is not appended for INIT sequences or for clk_timer=0.
REQ-031 Macro RTC_WR_TRANSFER_EN undefined: no command item; the WRITE list is always exactly 3 items.

Verification
REQ-032 T_PHASE=4, Escribe=1, clk_timer=0, Dir_*=0x41/0x42/0x43, data=0x00 -> bus writes (0x41,00),(0x42,00),(0x43,00); T_Esc=1 at cycle 85; Escribe=0 -> IDLE next cycle.
REQ-033 Escribe=1 and Inicializador_MP=1 in the same cycle -> INIT list (0x02,10),(0x02,00),(0x10,D2) only; WRITE list not executed.
REQ-034 Segundo changed 0x15 -> 0x30 during item 0 -> bus carries 0x15.
REQ-035 reset=0 during D_STROBE of item 1 -> WR_n=1, CS_n=1, bus_oe=0 immediately; a new Escribe after release writes the seconds register first.
REQ-036 RTC_WR_TRANSFER_EN defined, clk_timer=1, Dir_*=0x21/0x22/0x23 -> 3 writes then address-only 0xF1 with A_D=0 throughout it; T_Esc at cycle 101 (T_PHASE=4).
REQ-037 T_PHASE=1, Escribe pulsed one cycle -> full 3-item sequence in 21 cycles, DONE held exactly one cycle.
